// File: rtl/ipsl_ddrphy_update_exec_if.sv
// ipsl_ddrphy_update_exec_if: update-request, DFI handshake and delay-line signals of the update executor.
interface ipsl_ddrphy_update_exec_if;
  logic       update_start;
  logic [1:0] ddrphy_update_type;
  logic [1:0] ddrphy_update_comp_val_l;
  logic       ddrphy_update_comp_dir_l;
  logic [1:0] ddrphy_update_comp_val_h;
  logic       ddrphy_update_comp_dir_h;
  logic       dfi_phyupd_ack;
  logic       dfi_phyupd_req;
  logic       dll_update_n;
  logic [7:0] dqs_gate_dly_l;
  logic [7:0] dqs_gate_dly_h;
  logic       dly_load;
  logic       ddrphy_update_done;
  logic       update_busy;
  logic       timeout_err;
  modport master (
    output update_start, ddrphy_update_type, ddrphy_update_comp_val_l, ddrphy_update_comp_dir_l,
           ddrphy_update_comp_val_h, ddrphy_update_comp_dir_h, dfi_phyupd_ack,
    input  dfi_phyupd_req, dll_update_n, dqs_gate_dly_l, dqs_gate_dly_h, dly_load,
           ddrphy_update_done, update_busy, timeout_err
  );
  modport slave (
    input  update_start, ddrphy_update_type, ddrphy_update_comp_val_l, ddrphy_update_comp_dir_l,
           ddrphy_update_comp_val_h, ddrphy_update_comp_dir_h, dfi_phyupd_ack,
    output dfi_phyupd_req, dll_update_n, dqs_gate_dly_l, dqs_gate_dly_h, dly_load,
           ddrphy_update_done, update_busy, timeout_err
  );
endinterface

// File: rtl/ipsl_ddrphy_update_exec.sv
// ipsl_ddrphy_update_exec: DFI PHY-update sequencer applying DLL pulse, DQS gate compensation or reload.
// Define IPSL_DDRPHY_UPD_TIMEOUT_EN to abandon REQ after ACK_TIMEOUT cycles without ack.
module ipsl_ddrphy_update_exec #(
  parameter string      DATA_WIDTH    = "16BIT",
  parameter int         DLL_PULSE_CYC = 4,
  parameter int         SETTLE_CYC    = 16,
  parameter int         ACK_TIMEOUT   = 255,
  parameter logic [7:0] INIT_DLY      = 8'd32
) (
  input logic rclk,
  input logic rst,
  ipsl_ddrphy_update_exec_if.slave u
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, EXEC = 3'd2, SETTLE = 3'd3, DONE = 3'd4;
  localparam logic [7:0] PULSE_LAST  = 8'(DLL_PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam bit HI = DATA_WIDTH == "16BIT";
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, dly_l_q, dly_h_q;
  logic [1:0] type_q, vl_q, vh_q;
  logic       start_q, dl_q, dh_q, trig, exec_end, ack_to;
  function automatic logic [7:0] step(input logic [7:0] d, input logic [1:0] v, input logic up);
    logic [8:0] s;
    s = up ? {1'b0, d} + {7'b0, v} : {1'b0, d} - {7'b0, v};
    return s[8] ? (up ? 8'hff : 8'h00) : s[7:0];
  endfunction
  assign trig     = u.update_start & ~start_q & (state_q == IDLE);
  assign exec_end = (type_q != 2'b00) || (cnt_q == PULSE_LAST);
  always_comb begin
    state_d = (state_q == IDLE)   ? (trig ? REQ : IDLE)
            : (state_q == REQ)    ? (u.dfi_phyupd_ack ? EXEC : ack_to ? DONE : REQ)
            : (state_q == EXEC)   ? (exec_end ? SETTLE : EXEC)
            : (state_q == SETTLE) ? ((cnt_q == SETTLE_LAST) ? DONE : SETTLE)
            : IDLE;
    cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
  end
  always_ff @(posedge rclk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
      type_q  <= 2'b11;
      vl_q    <= 2'b00;
      vh_q    <= 2'b00;
      dl_q    <= 1'b0;
      dh_q    <= 1'b0;
      dly_l_q <= INIT_DLY;
      dly_h_q <= INIT_DLY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= u.update_start;
      if (trig) begin
        type_q <= u.ddrphy_update_type;
        vl_q   <= u.ddrphy_update_comp_val_l;
        vh_q   <= u.ddrphy_update_comp_val_h;
        dl_q   <= u.ddrphy_update_comp_dir_l;
        dh_q   <= u.ddrphy_update_comp_dir_h;
      end
      // new delays land on the REQ->EXEC edge so they are visible in the first EXEC cycle
      if (state_q == REQ && u.dfi_phyupd_ack && type_q == 2'b01) begin
        dly_l_q <= step(dly_l_q, vl_q, dl_q);
        if (HI) dly_h_q <= step(dly_h_q, vh_q, dh_q);
      end
    end
`ifdef IPSL_DDRPHY_UPD_TIMEOUT_EN
  logic [7:0] req_cnt_q;
  logic       terr_q;
  assign ack_to = (state_q == REQ) && !u.dfi_phyupd_ack && (req_cnt_q == 8'(ACK_TIMEOUT - 1));
  always_ff @(posedge rclk or posedge rst)
    if (rst) begin
      req_cnt_q <= 8'd0;
      terr_q    <= 1'b0;
    end else begin
      req_cnt_q <= (state_q == REQ) ? req_cnt_q + 8'd1 : 8'd0;
      if (ack_to) terr_q <= 1'b1;
    end
  assign u.timeout_err = terr_q;
`else
  assign ack_to        = 1'b0;
  assign u.timeout_err = 1'b0;
`endif
  assign u.dfi_phyupd_req     = (state_q == REQ) || (state_q == EXEC) || (state_q == SETTLE);
  assign u.dll_update_n       = !((state_q == EXEC) && (type_q == 2'b00));
  assign u.dly_load           = (state_q == EXEC) && (type_q[1] ^ type_q[0]);
  assign u.ddrphy_update_done = state_q == DONE;
  assign u.update_busy        = state_q != IDLE;
  assign u.dqs_gate_dly_l     = dly_l_q;
  assign u.dqs_gate_dly_h     = dly_h_q;
endmodule

// File: tb/tb_ipsl_ddrphy_update_exec.sv
// tb_ipsl_ddrphy_update_exec: randomized and directed checks of the update executor against a schedule model.
module tb_ipsl_ddrphy_update_exec;
  localparam int P = 4, SC = 16, TO = 10;
  logic rclk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0, ml = 32, mh = 32;
  bit terr_exp = 1'b0;
  logic [37:0] obs;
  always #5 rclk = ~rclk;
  ipsl_ddrphy_update_exec_if u();
  ipsl_ddrphy_update_exec_if u8();
  assign u8.update_start             = u.update_start;
  assign u8.ddrphy_update_type       = u.ddrphy_update_type;
  assign u8.ddrphy_update_comp_val_l = u.ddrphy_update_comp_val_l;
  assign u8.ddrphy_update_comp_dir_l = u.ddrphy_update_comp_dir_l;
  assign u8.ddrphy_update_comp_val_h = u.ddrphy_update_comp_val_h;
  assign u8.ddrphy_update_comp_dir_h = u.ddrphy_update_comp_dir_h;
  assign u8.dfi_phyupd_ack           = u.dfi_phyupd_ack;
  ipsl_ddrphy_update_exec #(.DATA_WIDTH("16BIT"), .DLL_PULSE_CYC(P), .SETTLE_CYC(SC),
    .ACK_TIMEOUT(TO), .INIT_DLY(8'd32)) dut (.rclk(rclk), .rst(rst), .u(u));
  ipsl_ddrphy_update_exec #(.DATA_WIDTH("8BIT"), .DLL_PULSE_CYC(P), .SETTLE_CYC(SC),
    .ACK_TIMEOUT(TO), .INIT_DLY(8'd32)) dut8 (.rclk(rclk), .rst(rst), .u(u8));
  assign obs = {u.dfi_phyupd_req, u.ddrphy_update_done, u.update_busy, u.dll_update_n, u.dly_load,
                u.timeout_err, u.dqs_gate_dly_l, u.dqs_gate_dly_h, u8.dqs_gate_dly_l, u8.dqs_gate_dly_h};

  function automatic int sat(input int d, input int v, input bit up);
    int r;
    r = up ? d + v : d - v;
    return r > 255 ? 255 : (r < 0 ? 0 : r);
  endfunction

  // one full sequence; expected outputs follow from the trigger-relative schedule
  task automatic run_seq(input string name, input logic [1:0] ty, input logic [1:0] vl, input bit dl,
                         input logic [1:0] vh, input bit dh, input int k, input bit hold, input bit glitch);
    int e, s, d, nl, nh;
    logic [37:0] exp;
    e = k + 1;
    s = e + (ty == 2'b00 ? P : 1);
    d = s + SC;
    nl = (ty == 2'b01) ? sat(ml, vl, dl) : ml;
    nh = (ty == 2'b01) ? sat(mh, vh, dh) : mh;
    @(posedge rclk); #1;
    u.update_start = 1'b0;
    u.dfi_phyupd_ack = 1'b0;
    @(posedge rclk); #1;
    u.update_start = 1'b1;
    u.ddrphy_update_type = ty;
    u.ddrphy_update_comp_val_l = vl;
    u.ddrphy_update_comp_dir_l = dl;
    u.ddrphy_update_comp_val_h = vh;
    u.ddrphy_update_comp_dir_h = dh;
    for (int c = 1; c <= d + 1; c++) begin
      @(posedge rclk); #1;
      u.ddrphy_update_type = 2'($urandom);
      u.ddrphy_update_comp_val_l = 2'($urandom);
      u.ddrphy_update_comp_val_h = 2'($urandom);
      u.ddrphy_update_comp_dir_l = 1'($urandom);
      u.ddrphy_update_comp_dir_h = 1'($urandom);
      u.dfi_phyupd_ack = (c >= k) && (c < d);
      if (!hold && c == 2) u.update_start = 1'b0;
      if (glitch && c == s + 1) u.update_start = 1'b0;
      if (glitch && c == s + 3) u.update_start = 1'b1;
      @(negedge rclk);
      exp = {c < d, c == d, c <= d, !(ty == 2'b00 && c >= e && c < e + P),
             (ty == 2'b01 || ty == 2'b10) && c == e, terr_exp,
             8'(c >= e ? nl : ml), 8'(c >= e ? nh : mh), 8'(c >= e ? nl : ml), 8'd32};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
      end
    end
    ml = nl;
    mh = nh;
  endtask

  task automatic test_reset();
    @(negedge rclk);
    n_chk++;
    if (obs !== {6'b000100, 8'd32, 8'd32, 8'd32, 8'd32}) begin
      n_fail++;
      $display("FAIL reset_values: got %h", obs);
    end
    @(posedge rclk); #1;
    rst = 1'b0;
  endtask

  task automatic test_dll();
    run_seq("dll", 2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 4, 1'b0, 1'b0);
  endtask

  task automatic test_dqs();
    run_seq("dqs", 2'b01, 2'd2, 1'b1, 2'd1, 1'b0, 2, 1'b0, 1'b0);
    n_chk++;
    if (u.dqs_gate_dly_l !== 8'd34 || u.dqs_gate_dly_h !== 8'd31) begin
      n_fail++;
      $display("FAIL dqs_values: got l=%0d h=%0d expected l=34 h=31", u.dqs_gate_dly_l, u.dqs_gate_dly_h);
    end
  endtask

  task automatic move_l(input int target);
    int v;
    while (ml != target) begin
      v = (ml > target) ? ml - target : target - ml;
      run_seq("move_l", 2'b01, 2'(v > 3 ? 3 : v), ml < target, 2'd0, 1'b0, 1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_saturation();
    move_l(254);
    run_seq("sat_hi", 2'b01, 2'd2, 1'b1, 2'd0, 1'b0, 1, 1'b0, 1'b0);
    n_chk++;
    if (u.dqs_gate_dly_l !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hi_value: got %0d expected 255", u.dqs_gate_dly_l);
    end
    move_l(1);
    run_seq("sat_lo", 2'b01, 2'd3, 1'b0, 2'd0, 1'b0, 1, 1'b0, 1'b0);
    n_chk++;
    if (u.dqs_gate_dly_l !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_lo_value: got %0d expected 0", u.dqs_gate_dly_l);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_seq("random", 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(1, 5)), 1'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("held_glitch", 2'b01, 2'd1, 1'b1, 2'd1, 1'b1, 1, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      n_chk++;
      if ({u.update_busy, u.dfi_phyupd_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL held_no_retrigger cycle %0d: busy/req got %b expected 00", c, {u.update_busy, u.dfi_phyupd_req});
      end
    end
    run_seq("retrigger", 2'b10, 2'd0, 1'b0, 2'd0, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef IPSL_DDRPHY_UPD_TIMEOUT_EN
    logic [37:0] exp;
    @(posedge rclk); #1;
    u.update_start = 1'b0;
    u.dfi_phyupd_ack = 1'b0;
    @(posedge rclk); #1;
    u.update_start = 1'b1;
    u.ddrphy_update_type = 2'b01;
    u.ddrphy_update_comp_val_l = 2'd3;
    u.ddrphy_update_comp_dir_l = 1'b1;
    u.ddrphy_update_comp_val_h = 2'd3;
    u.ddrphy_update_comp_dir_h = 1'b0;
    for (int c = 1; c <= TO + 3; c++) begin
      @(negedge rclk);
      exp = {c <= TO, c == TO + 1, c <= TO + 1, 1'b1, 1'b0, c >= TO + 1,
             8'(ml), 8'(mh), 8'(ml), 8'd32};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h expected %h", c, obs, exp);
      end
    end
    terr_exp = 1'b1;
`else
    run_seq("no_timeout", 2'b01, 2'd3, 1'b1, 2'd3, 1'b0, 40, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    @(posedge rclk); #1;
    u.update_start = 1'b0;
    u.dfi_phyupd_ack = 1'b0;
    u.ddrphy_update_type = 2'b00;
    @(posedge rclk); #1;
    u.update_start = 1'b1;
    @(posedge rclk); #1;
    u.dfi_phyupd_ack = 1'b1;
    @(posedge rclk); #1;
    @(posedge rclk); #1;
    n_chk++;
    if (u.dll_update_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pulse: dll_update_n got %b expected 0", u.dll_update_n);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs !== {6'b000100, 8'd32, 8'd32, 8'd32, 8'd32}) begin
      n_fail++;
      $display("FAIL reset_mid_exec: got %h", obs);
    end
    ml = 32;
    mh = 32;
    terr_exp = 1'b0;
    @(posedge rclk); #1;
    rst = 1'b0;
    u.update_start = 1'b0;
    u.dfi_phyupd_ack = 1'b0;
    run_seq("after_reset", 2'b01, 2'd2, 1'b0, 2'd3, 1'b1, 3, 1'b0, 1'b0);
  endtask

  initial begin
    u.update_start = 1'b0;
    u.ddrphy_update_type = 2'b00;
    u.ddrphy_update_comp_val_l = 2'd0;
    u.ddrphy_update_comp_dir_l = 1'b0;
    u.ddrphy_update_comp_val_h = 2'd0;
    u.ddrphy_update_comp_dir_h = 1'b0;
    u.dfi_phyupd_ack = 1'b0;
    test_reset();
    test_dll();
    test_dqs();
    test_saturation();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end
endmodule

// File: doc/ipsl_ddrphy_update_exec.md
# ipsl_ddrphy_update_exec

Executes PHY-initiated update requests issued by the DDR PHY update controller. On a rising edge of `update_start` it runs the DFI PHY-update handshake with the memory controller, applies the requested action (DLL refresh pulse, DQS gate-delay compensation, or manual reload), waits a settle period, and returns a one-cycle `ddrphy_update_done`. It sits directly downstream of the update controller and upstream of the DLL and DQS delay-line ports in `rclk` domain.

## Interface
- `DATA_WIDTH`, "16BIT": "16BIT" or "8BIT"; the high-lane path is active only for "16BIT".
- `DLL_PULSE_CYC`, 4: `dll_update_n` low-pulse length in cycles (1-15).
- `SETTLE_CYC`, 16: post-action settle cycles before done (1-255).
- `ACK_TIMEOUT`, 255: maximum REQ cycles without ack (1-255). Used only with the timeout feature.
- `INIT_DLY`, 8'd32: reset value of both gate-delay outputs.
- `rclk` in 1: clock. One clock; every port is synchronous to it.
- `rst` in 1: reset, asynchronous, active-high.
- `update_start` in 1: level from the update controller; the sequence is triggered on its rising edge.
- `ddrphy_update_type` in 2: 00 DLL, 01 DQS drift, 10 manual, 11 no-op.
- `ddrphy_update_comp_val_l` in 2, `ddrphy_update_comp_dir_l` in 1: low-lane step count and direction (1 = increment).
- `ddrphy_update_comp_val_h` in 2, `ddrphy_update_comp_dir_h` in 1: high-lane equivalents.
- `dfi_phyupd_ack` in 1: controller grant.
- `dfi_phyupd_req` out 1: PHY update request.
- `dll_update_n` out 1: DLL update strobe, active low.
- `dqs_gate_dly_l` out 8, `dqs_gate_dly_h` out 8: current gate-delay settings.
- `dly_load` out 1: one-cycle load strobe for the delay lines.
- `ddrphy_update_done` out 1: one-cycle completion pulse.
- `update_busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky ack-timeout flag; cleared only by `rst`.

## Operation
- Reset values:
  - `dfi_phyupd_req`, `dly_load`, `ddrphy_update_done`, `update_busy`, `timeout_err` reset to 0.
  - `dll_update_n` resets to 1.
  - Both gate-delay outputs reset to `INIT_DLY`.
  - FSM resets to IDLE.
- Edge detect: a registered copy `start_d` of `update_start` is kept. A trigger is `update_start & ~start_d` while in IDLE. Type and comp inputs are captured in the trigger cycle.
- Triggers outside IDLE are ignored. Falling `update_start` mid-sequence is ignored; the sequence always completes.
- IDLE: on a trigger, go to REQ.
- REQ: `dfi_phyupd_req`=1.
  - `dfi_phyupd_ack`=1 sampled: go to EXEC.
  - Ack timeout (feature only): go to DONE and set `timeout_err`; no action is applied.
- EXEC:
  - Type 00: `dll_update_n`=0 for `DLL_PULSE_CYC` cycles, then go to SETTLE.
  - Type 01: in the first EXEC cycle, compute lane delay = dly ± val with saturation to 0..255, and set `dly_load`=1 for one cycle. Go to SETTLE next cycle. The high lane updates only when `DATA_WIDTH`=="16BIT"; otherwise `dqs_gate_dly_h` holds `INIT_DLY`.
  - Type 10: `dly_load` pulse with delays unchanged, then go to SETTLE.
  - Type 11: go straight to SETTLE.
- SETTLE: count `SETTLE_CYC` cycles with `dfi_phyupd_req` still 1, then go to DONE.
- DONE: one cycle with `ddrphy_update_done`=1 and `dfi_phyupd_req`=0, then go to IDLE.
- Arithmetic: 9-bit intermediate; clamp at 255 on increment and at 0 on decrement; val=0 leaves the delay unchanged.

## Timing
- Trigger at cycle T: REQ and `dfi_phyupd_req`=1 from T+1.
- Ack high at cycle A (A ≥ T+1, including ack already high at T+1): EXEC at A+1.
- DLL: `dll_update_n` low A+1..A+`DLL_PULSE_CYC`; SETTLE starts at A+`DLL_PULSE_CYC`+1.
- DQS/manual: new delays and `dly_load` valid at A+1; SETTLE starts at A+2.
- Done asserts `SETTLE_CYC` cycles after SETTLE entry. The earliest re-trigger is the cycle after DONE, but `update_start` must first fall and rise again.
- `rst` mid-sequence: all outputs return to reset values asynchronously, and accumulated delays revert to `INIT_DLY`.

## Configuration
- `IPSL_DDRPHY_UPD_TIMEOUT_EN` defined:
  - An 8-bit REQ counter is built.
  - When REQ has lasted `ACK_TIMEOUT` cycles without ack, the FSM goes to DONE, `timeout_err` is set, and done is pulsed.
- Undefined: REQ waits indefinitely, the counter is not built, and `timeout_err` is tied 0.

## Test plan
- DLL update: type 00, ack 3 cycles after req, `DLL_PULSE_CYC`=4, `SETTLE_CYC`=16 -> `dll_update_n` low exactly 4 cycles; done one cycle, 20 cycles after EXEC entry; req drops with done.
- DQS compensation: type 01, l val 2 dir 1, h val 1 dir 0 from 32/32 -> `dqs_gate_dly_l`=34, `dqs_gate_dly_h`=31, single `dly_load` pulse. With `DATA_WIDTH`="8BIT", `dqs_gate_dly_h` stays 32.
- Saturation: `dqs_gate_dly_l`=254, val 2 dir 1 -> 255; then at 1, val 3 dir 0 -> 0.
- Held/retriggered start: `update_start` held high across done, then a new rising edge issued during SETTLE -> exactly one sequence; a second starts only after a low-then-high edge following IDLE.
- Timeout (macro defined): ack never asserted, `ACK_TIMEOUT`=10 -> done 10 REQ cycles later, `timeout_err`=1 sticky, delays unchanged. Macro undefined: req stays high indefinitely.
- Reset mid-EXEC: `rst` asserted during the DLL pulse -> `dll_update_n`=1, req=0, delays=`INIT_DLY` immediately; the next trigger runs a normal sequence.
